// File: rtl/rms_mc_pkg.sv
// Shared constants and width helpers for the multi-channel sliding-window RMS engine.
package rms_mc_pkg;

  typedef longint unsigned u64_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_MEAN  = 3'd3;
  localparam logic [2:0] ST_SQRT  = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int sq_width(input int w);
    return 2 * w;
  endfunction

  // A sum of at most n squares needs clog2(n) guard bits above the square width.
  function automatic int sum_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // round(2^bits / n), so the mean becomes a multiply and a shift.
  function automatic u64_t recip_const(input int n, input int bits);
    u64_t one;
    one = 1;
    return ((one << bits) + u64_t'(n / 2)) / u64_t'(n);
  endfunction

endpackage

// File: rtl/rms_isqrt.sv
// Iterative non-restoring integer square root: one root bit per cycle, start/done handshake.
module rms_isqrt #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           done,
  output logic [W-1:0]   root
);

  localparam int RW   = W + 2;
  localparam int CNTW = $clog2(W + 1);

  logic [RW-1:0]   rem;
  logic [RW-1:0]   rem_shift;
  logic [RW-1:0]   rem_next;
  logic [2*W-1:0]  rad;
  logic [W-1:0]    root_next;
  logic [CNTW-1:0] cnt;
  logic            busy;

  // Remainder sign selects subtract (non-negative) or add-back (negative) for the next digit.
  always_comb begin
    rem_shift = {rem[RW-3:0], rad[2*W-1 -: 2]};
    if (!rem[RW-1]) begin
      rem_next = rem_shift - {root, 2'b01};
    end else begin
      rem_next = rem_shift + {root, 2'b11};
    end
    root_next = {root[W-2:0], ~rem_next[RW-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CNTW'(W);
      end else if (busy) begin
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem  <= '0;
      root <= '0;
      rad  <= radicand;
    end else if (busy) begin
      rem  <= rem_next;
      root <= root_next;
      rad  <= rad << 2;
    end
  end

endmodule

// File: rtl/axis_true_rms_mc_v2_0.sv
// Multi-channel sliding-window true-RMS over a time-multiplexed AXI-Stream, one sample in flight.
module axis_true_rms_mc_v2_0
  import rms_mc_pkg::*;
#(
  parameter int inout_width      = 16,
  parameter int inout_fractional = 15,
  parameter int rms_nsamples     = 43,
  parameter int channels         = 4,
  parameter int recip_bits       = 24
) (
  input  logic                             aclk,
  input  logic                             reset,
  input  logic signed [inout_width-1:0]    s_axis_tdata,
  input  logic [ch_width(channels)-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [inout_width-1:0]           m_axis_tdata,
  output logic [ch_width(channels)-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [channels-1:0]              window_full
);

  localparam int W     = inout_width;
  localparam int N     = rms_nsamples;
  localparam int CW    = ch_width(channels);
  localparam int SQW   = sq_width(W);
  localparam int SUMW  = sum_width(W, N);
  localparam int RB    = recip_bits;
  localparam int PRODW = SUMW + RB + 1;
  localparam int PTRW  = $clog2(N);
  localparam int FILLW = $clog2(N + 1);
  localparam int DEPTH = channels * N;
  localparam int ADDRW = $clog2(DEPTH);

  localparam u64_t             RECIP_L  = recip_const(N, RB);
  localparam logic [RB:0]      RECIP    = RECIP_L[RB:0];
  localparam logic [FILLW-1:0] N_FILL   = FILLW'(N);
  localparam logic [PTRW-1:0]  PTR_LAST = PTRW'(N - 1);
  localparam logic [ADDRW-1:0] N_ADDR   = ADDRW'(N);
  localparam logic [CW:0]      CH_LIM   = (CW + 1)'(channels);

  // Same Q format in and out: Q(2F) mean square -> Q(F) root, so F needs no scaling here.
  function automatic logic [W-1:0] sat_root(input logic [W-1:0] r);
    return r[W-1] ? {1'b0, {(W-1){1'b1}}} : r;
  endfunction

  logic [2:0]              state;
  logic                    tready_q;
  logic signed [W-1:0]     x_p0;
  logic [CW-1:0]           ch_p0;
  logic [SQW-1:0]          sq_p1;
  logic [SQW-1:0]          rd_p1;
  logic [SUMW-1:0]         sums [channels];
  logic [PTRW-1:0]         wptr [channels];
  logic [FILLW-1:0]        fill [channels];
  logic [SQW-1:0]          ram  [DEPTH];

  logic                    accept;
  logic                    ch_ok;
  logic [ADDRW-1:0]        addr;
  logic signed [SQW-1:0]   x_ext;
  logic signed [SQW-1:0]   sq_full;
  logic [SQW-1:0]          old_sq;
  logic [SUMW-1:0]         sum_next;
  logic [PRODW-1:0]        prod;
  logic [SQW-1:0]          ms;
  logic                    sqrt_start;
  logic                    sqrt_done;
  logic [W-1:0]            root;

  assign s_axis_tready = tready_q;

  always_comb begin
    accept     = s_axis_tvalid && tready_q;
    ch_ok      = {1'b0, s_axis_tuser} < CH_LIM;
    addr       = ADDRW'(ch_p0) * N_ADDR + ADDRW'(wptr[ch_p0]);
    x_ext      = SQW'(x_p0);
    sq_full    = x_ext * x_ext;
    old_sq     = (fill[ch_p0] < N_FILL) ? '0 : rd_p1;
    sum_next   = sums[ch_p0] + SUMW'(sq_p1) - SUMW'(old_sq);
    prod       = PRODW'(sums[ch_p0]) * PRODW'(RECIP);
    ms         = SQW'(prod >> RB);
    sqrt_start = (state == ST_MEAN);
  end

  // p0: latch sample; p1: square and oldest-square read; ACCUM writes the new square back.
  always_ff @(posedge aclk) begin
    if (state == ST_IDLE && accept) begin
      x_p0  <= s_axis_tdata;
      ch_p0 <= s_axis_tuser;
    end
    if (state == ST_READ) begin
      sq_p1 <= sq_full;
      rd_p1 <= ram[addr];
    end
    if (state == ST_ACCUM) begin
      ram[addr] <= sq_p1;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      tready_q      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      window_full   <= '0;
      for (int c = 0; c < channels; c++) begin
        sums[c] <= '0;
        wptr[c] <= '0;
        fill[c] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          tready_q <= 1'b1;
          // Unknown channel ids are consumed without touching any state.
          if (accept && ch_ok) begin
            state    <= ST_READ;
            tready_q <= 1'b0;
          end
        end
        ST_READ: state <= ST_ACCUM;
        ST_ACCUM: begin
          sums[ch_p0] <= sum_next;
          wptr[ch_p0] <= (wptr[ch_p0] == PTR_LAST) ? '0 : wptr[ch_p0] + PTRW'(1);
          if (fill[ch_p0] < N_FILL) begin
            fill[ch_p0] <= fill[ch_p0] + FILLW'(1);
            if (fill[ch_p0] == N_FILL - FILLW'(1)) begin
              window_full[ch_p0] <= 1'b1;
            end
          end
          state <= ST_MEAN;
        end
        ST_MEAN: state <= ST_SQRT;
        ST_SQRT: begin
          if (sqrt_done) begin
            m_axis_tdata  <= sat_root(root);
            m_axis_tuser  <= ch_p0;
            m_axis_tvalid <= 1'b1;
            state         <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            tready_q      <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rms_isqrt #(
    .W(W)
  ) u_isqrt (
    .clk      (aclk),
    .rst      (reset),
    .start    (sqrt_start),
    .radicand (ms),
    .done     (sqrt_done),
    .root     (root)
  );

endmodule

// File: tb/tb_axis_true_rms_mc_v2_0.sv
// Randomized and directed bench for axis_true_rms_mc_v2_0 against a queue-based window model.
module tb_axis_true_rms_mc_v2_0;

  localparam int W   = 16;
  localparam int N   = 43;
  localparam int C   = 4;
  localparam int RB  = 24;
  localparam int CW  = 2;
  localparam int LAT = W + 5;  // negedges from the accepting edge to the first visible tvalid

  logic                 aclk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [W-1:0]  s_axis_tdata = '0;
  logic [CW-1:0]        s_axis_tuser = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [W-1:0]         m_axis_tdata;
  logic [CW-1:0]        m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b1;
  logic [C-1:0]         window_full;

  always #5 aclk = ~aclk;

  axis_true_rms_mc_v2_0 #(
    .inout_width(W), .inout_fractional(15), .rms_nsamples(N), .channels(C), .recip_bits(RB)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .window_full   (window_full)
  );

  int     n_chk  = 0;
  int     n_pass = 0;
  int     hist [C][$];
  longint recip;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // RMS of the last N samples; the divisor stays N while the window is filling.
  function automatic longint model_rms(input int ch);
    longint s, ms, r, t;
    s = 0;
    r = 0;
    for (int i = 0; i < hist[ch].size(); i++) s += longint'(hist[ch][i]) * longint'(hist[ch][i]);
    ms = ((s * recip) >> RB) & 64'hFFFF_FFFF;
    for (int b = W - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= ms) r = t;
    end
    if (r > 32767) r = 32767;
    return r;
  endfunction

  function automatic longint model_full();
    longint f;
    f = 0;
    for (int c = 0; c < C; c++) if (hist[c].size() == N) f |= (longint'(1) << c);
    return f;
  endfunction

  function automatic int sine(input int k);
    real v;
    v = 0.9 * 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / real'(N));
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic longint absdiff(input longint a, input longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic run_sample(input int ch, input int x, input int stall, output longint got);
    int t;
    logic [W-1:0]  td;
    logic [CW-1:0] tu;
    got = -1;
    m_axis_tready = (stall == 0);
    @(negedge aclk);
    s_axis_tdata  = x[W-1:0];
    s_axis_tuser  = ch[CW-1:0];
    s_axis_tvalid = 1'b1;
    t = 0;
    while (!s_axis_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!s_axis_tready) begin
      check("accept_timeout", 0, 1);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      return;
    end
    @(posedge aclk);
    #1 s_axis_tvalid = 1'b0;
    hist[ch].push_back(x);
    if (hist[ch].size() > N) void'(hist[ch].pop_front());
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!m_axis_tvalid && t < 100);
    check("latency", t, LAT);
    if (!m_axis_tvalid) begin
      m_axis_tready = 1'b1;
      return;
    end
    td = m_axis_tdata;
    tu = m_axis_tuser;
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      check("hold_tvalid", m_axis_tvalid, 1);
      check("hold_tdata", m_axis_tdata, td);
      check("hold_tuser", m_axis_tuser, tu);
      check("hold_s_tready", s_axis_tready, 0);
    end
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    check("tvalid_drop", m_axis_tvalid, 0);
    got = td;
    check("tdata", td, model_rms(ch));
    check("tuser", tu, ch);
    check("window_full", window_full, model_full());
  endtask

  initial begin
    longint g, g0, g1;
    int pulses;
    recip = ((longint'(1) << RB) + N / 2) / N;

    repeat (3) @(negedge aclk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tuser", m_axis_tuser, 0);
    check("rst_window_full", window_full, 0);
    reset = 1'b0;
    @(negedge aclk);
    check("s_tready_after_rst", s_axis_tready, 1);

    // DC ramp-up on ch0
    for (int k = 1; k <= N; k++) begin
      run_sample(0, 16384, 0, g);
      if (k == 1) check("dc_first", g, 2498);
    end
    check("dc_full_tol", absdiff(g, 16384) <= 1, 1);
    check("dc_window_full0", window_full[0], 1);

    // interleaved ch0 sine / ch1 zeros
    for (int k = 0; k < 2 * N; k++) begin
      run_sample(0, sine(k), 0, g0);
      if (k >= N) check("sine_rms_tol", absdiff(g0, 20853) <= 2, 1);
      run_sample(1, 0, 0, g1);
      check("ch1_zero", g1, 0);
    end

    // full-scale negative on ch2
    for (int k = 1; k <= N; k++) begin
      run_sample(2, -32768, 0, g);
      check("neg_nonzero", g > 0, 1);
    end
    check("neg_saturated", g, 32767);

    // back-pressure in OUT, then the following sample must still be processed
    run_sample(3, 12345, 20, g);
    run_sample(3, -2000, 0, g);

    for (int i = 0; i < 60; i++) begin
      run_sample($urandom_range(0, C - 1), int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 3), g);
    end

    // reset while the root is being computed
    m_axis_tready = 1'b1;
    @(negedge aclk);
    s_axis_tdata  = 16'sd1000;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b1;
    @(posedge aclk);
    #1 s_axis_tvalid = 1'b0;
    repeat (8) @(negedge aclk);
    reset = 1'b1;
    #1;
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_window_full", window_full, 0);
    repeat (2) @(negedge aclk);
    reset = 1'b0;
    for (int c = 0; c < C; c++) hist[c].delete();
    pulses = 0;
    repeat (30) begin
      @(negedge aclk);
      if (m_axis_tvalid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    run_sample(0, 16384, 0, g);
    check("post_rst_dc_tol", absdiff(g, 2498) <= 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
